// File: rtl/arm_mem_pkg.sv
// Shared definitions for the multi-cycle MEM stage: FSM state encoding and the
// default SRAM latency / base address reused by the SRAM model and freeze logic.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;

endpackage

// File: rtl/mem_stage_sram.sv
// Multi-cycle MEM stage: sequences one fixed-latency external SRAM access per
// load/store and stalls the upstream pipeline via freeze until it completes.
module mem_stage_sram
  import arm_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 16,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_w_en_input,
  input  logic                  mem_r_en_input,
  input  logic                  wb_en_input,
  input  logic [3:0]            dest_input,
  input  logic [ADDR_W-1:0]     alu_res_input,
  input  logic [DATA_W-1:0]     val_rm_i,
  output logic                  wb_en_output,
  output logic                  mem_r_en_output,
  output logic [3:0]            dest_output,
  output logic [ADDR_W-1:0]     alu_res_output,
  output logic [DATA_W-1:0]     data_mem_output,
  output logic                  freeze,
  output logic [MEM_ADDR_W-1:0] ext_addr,
  output logic                  ext_w_en,
  output logic                  ext_r_en,
  output logic [DATA_W-1:0]     ext_wdata,
  input  logic [DATA_W-1:0]     ext_rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

  // Byte address -> external word address; out-of-range offsets wrap silently.
  function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return MEM_ADDR_W'((byte_addr - ADDR_W'(BASE_ADDR)) >> 2);
  endfunction

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic                   freeze_c;
  logic                   req;

  assign req = mem_r_en_input | mem_w_en_input;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    freeze_c = 1'b0;
    ext_w_en = 1'b0;
    ext_r_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          freeze_c = 1'b1;
          addr_d   = word_addr(alu_res_input);
          wdata_d  = val_rm_i;
          // A combined read/write request is treated as a pure store.
          wr_d     = mem_w_en_input;
          rd_d     = mem_r_en_input & ~mem_w_en_input;
          cnt_d    = '0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        freeze_c = 1'b1;
        ext_w_en = wr_q;
        ext_r_en = rd_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          if (rd_q) rdata_d = ext_rdata;
          state_d = ST_DONE;
        end
      end
      // The frozen request is still on the inputs here; ignore it.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign freeze          = freeze_c & ~rst;
  assign ext_addr        = addr_q;
  assign ext_wdata       = wdata_q;
  assign data_mem_output = rdata_q;

  assign wb_en_output    = wb_en_input;
  assign mem_r_en_output = mem_r_en_input;
  assign dest_output     = dest_input;
  assign alu_res_output  = alu_res_input;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with an inline fixed-latency SRAM model.
module tb_mem_stage_sram;
  import arm_mem_pkg::*;

  localparam int WAIT = DEF_WAIT_CYCLES;
  localparam int BASE = DEF_BASE_ADDR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w_en_input = 1'b0, mem_r_en_input = 1'b0, wb_en_input = 1'b0;
  logic [3:0]  dest_input = '0;
  logic [31:0] alu_res_input = '0, val_rm_i = '0;
  logic        wb_en_output, mem_r_en_output, freeze, ext_w_en, ext_r_en;
  logic [3:0]  dest_output;
  logic [31:0] alu_res_output, data_mem_output, ext_wdata, ext_rdata;
  logic [15:0] ext_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram #(
    .DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(16), .WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_w_en_input(mem_w_en_input), .mem_r_en_input(mem_r_en_input),
    .wb_en_input(wb_en_input), .dest_input(dest_input),
    .alu_res_input(alu_res_input), .val_rm_i(val_rm_i),
    .wb_en_output(wb_en_output), .mem_r_en_output(mem_r_en_output),
    .dest_output(dest_output), .alu_res_output(alu_res_output),
    .data_mem_output(data_mem_output), .freeze(freeze),
    .ext_addr(ext_addr), .ext_w_en(ext_w_en), .ext_r_en(ext_r_en),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
  );

  // SRAM model: read data is only presented in the last cycle of a read burst.
  logic [31:0] sram_mem [256] = '{default: '0};
  int mcnt = 0;
  always @(posedge clk) begin
    if (ext_w_en) sram_mem[ext_addr[7:0]] <= ext_wdata;
    mcnt <= ext_r_en ? mcnt + 1 : 0;
  end
  assign ext_rdata = (ext_r_en && mcnt == WAIT - 1) ? sram_mem[ext_addr[7:0]] : 32'hBAD0_BAD0;

  // Observations of the latest access
  int          freeze_cnt, wen_cnt, ren_cnt, strobe_first;
  logic [15:0] addr_seen;
  logic [31:0] wdata_seen, dmo_pre, dmo_done;
  logic        addr_stable;

  task automatic set_idle();
    mem_w_en_input = 1'b0; mem_r_en_input = 1'b0; wb_en_input = 1'b0;
    dest_input = '0; alu_res_input = '0; val_rm_i = '0;
  endtask

  // Called just after a rising edge; holds the request through DONE, drops it after.
  task automatic run_op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    mem_w_en_input = w; mem_r_en_input = r; wb_en_input = r;
    dest_input = 4'h3; alu_res_input = a; val_rm_i = d;
    freeze_cnt = 0; wen_cnt = 0; ren_cnt = 0; strobe_first = -1;
    addr_seen = '0; wdata_seen = '0; addr_stable = 1'b1;
    for (int k = 0; k <= WAIT + 1; k++) begin
      @(negedge clk);
      if (freeze) freeze_cnt++;
      if (ext_w_en) wen_cnt++;
      if (ext_r_en) ren_cnt++;
      if (ext_w_en || ext_r_en) begin
        if (strobe_first < 0) begin
          strobe_first = k; addr_seen = ext_addr; wdata_seen = ext_wdata;
        end else if (ext_addr !== addr_seen) addr_stable = 1'b0;
      end
      if (k == WAIT) dmo_pre = data_mem_output;
      if (k == WAIT + 1) dmo_done = data_mem_output;
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en_input = 1'b1; alu_res_input = 32'd1028;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL rst_freeze got=%b exp=0", freeze); end
      checks++; if (data_mem_output !== 32'h0) begin failures++; $display("FAIL rst_dmo got=%h exp=0", data_mem_output); end
      checks++;
      if (ext_r_en !== 1'b0 || ext_w_en !== 1'b0 || ext_addr !== 16'h0 || ext_wdata !== 32'h0) begin
        failures++;
        $display("FAIL rst_ext got r=%b w=%b a=%h d=%h exp all 0", ext_r_en, ext_w_en, ext_addr, ext_wdata);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0);
    checks++; if (strobe_first !== 1) begin failures++; $display("FAIL rst_release_start got=%0d exp=1", strobe_first); end
    checks++; if (freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL rst_release_freeze got=%0d exp=%0d", freeze_cnt, WAIT + 1); end
    checks++; if (ren_cnt !== WAIT) begin failures++; $display("FAIL rst_release_ren got=%0d exp=%0d", ren_cnt, WAIT); end
  endtask

  task automatic test_store_load();
    run_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    checks++; if (wen_cnt !== WAIT) begin failures++; $display("FAIL st_wen got=%0d exp=%0d", wen_cnt, WAIT); end
    checks++; if (ren_cnt !== 0) begin failures++; $display("FAIL st_ren got=%0d exp=0", ren_cnt); end
    checks++; if (freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL st_freeze got=%0d exp=%0d", freeze_cnt, WAIT + 1); end
    checks++; if (addr_seen !== 16'd1 || !addr_stable) begin failures++; $display("FAIL st_addr got=%h stable=%b exp=0001", addr_seen, addr_stable); end
    checks++; if (wdata_seen !== 32'hDEADBEEF) begin failures++; $display("FAIL st_wdata got=%h exp=deadbeef", wdata_seen); end
    checks++; if (dmo_done !== 32'h0) begin failures++; $display("FAIL st_dmo_held got=%h exp=0", dmo_done); end
    @(negedge clk);
    checks++; if (freeze !== 1'b0 || ext_w_en !== 1'b0) begin failures++; $display("FAIL st_after got f=%b w=%b exp 0", freeze, ext_w_en); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0);
    checks++; if (ren_cnt !== WAIT) begin failures++; $display("FAIL ld_ren got=%0d exp=%0d", ren_cnt, WAIT); end
    checks++; if (wen_cnt !== 0) begin failures++; $display("FAIL ld_wen got=%0d exp=0", wen_cnt); end
    checks++; if (freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL ld_freeze got=%0d exp=%0d", freeze_cnt, WAIT + 1); end
    checks++; if (dmo_pre !== 32'h0) begin failures++; $display("FAIL ld_dmo_early got=%h exp=0", dmo_pre); end
    checks++; if (dmo_done !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_dmo got=%h exp=deadbeef", dmo_done); end
  endtask

  task automatic test_non_mem();
    alu_res_input = 32'h55; wb_en_input = 1'b1; dest_input = 4'hA; val_rm_i = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (freeze !== 1'b0 || ext_r_en !== 1'b0 || ext_w_en !== 1'b0) begin
        failures++; $display("FAIL nm_idle got f=%b r=%b w=%b exp 0", freeze, ext_r_en, ext_w_en);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (wb_en_output !== 1'b1 || dest_output !== 4'hA || alu_res_output !== 32'h55 || mem_r_en_output !== 1'b0) begin
      failures++;
      $display("FAIL nm_pass got wb=%b dest=%h alu=%h mr=%b exp 1/a/55/0", wb_en_output, dest_output, alu_res_output, mem_r_en_output);
    end
    checks++; if (data_mem_output !== 32'hDEADBEEF) begin failures++; $display("FAIL nm_dmo got=%h exp=deadbeef", data_mem_output); end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b0, 32'd1024, 32'h11);
    run_op(1'b1, 1'b0, 32'd1032, 32'h22);
    // Loads issued with no gap: second request appears in the first IDLE after DONE.
    run_op(1'b0, 1'b1, 32'd1024, 32'h0);
    mem_r_en_input = 1'b1; alu_res_input = 32'd1032;
    checks++; if (addr_seen !== 16'd0) begin failures++; $display("FAIL b2b_addr0 got=%h exp=0000", addr_seen); end
    checks++; if (dmo_done !== 32'h11) begin failures++; $display("FAIL b2b_dmo0 got=%h exp=00000011", dmo_done); end
    checks++; if (freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL b2b_freeze0 got=%0d exp=%0d", freeze_cnt, WAIT + 1); end
    run_op(1'b0, 1'b1, 32'd1032, 32'h0);
    checks++; if (strobe_first !== 1) begin failures++; $display("FAIL b2b_start1 got=%0d exp=1", strobe_first); end
    checks++; if (addr_seen !== 16'd2 || !addr_stable) begin failures++; $display("FAIL b2b_addr1 got=%h stable=%b exp=0002", addr_seen, addr_stable); end
    checks++; if (dmo_done !== 32'h22) begin failures++; $display("FAIL b2b_dmo1 got=%h exp=00000022", dmo_done); end
    checks++; if (freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL b2b_freeze1 got=%0d exp=%0d", freeze_cnt, WAIT + 1); end
    checks++; if (ren_cnt !== WAIT) begin failures++; $display("FAIL b2b_ren1 got=%0d exp=%0d", ren_cnt, WAIT); end
  endtask

  task automatic test_rw_both();
    run_op(1'b1, 1'b1, 32'd1036, 32'hCAFE0001);
    checks++; if (wen_cnt !== WAIT) begin failures++; $display("FAIL rw_wen got=%0d exp=%0d", wen_cnt, WAIT); end
    checks++; if (ren_cnt !== 0) begin failures++; $display("FAIL rw_ren got=%0d exp=0", ren_cnt); end
    checks++; if (addr_seen !== 16'd3) begin failures++; $display("FAIL rw_addr got=%h exp=0003", addr_seen); end
    checks++; if (dmo_done !== 32'h22) begin failures++; $display("FAIL rw_dmo got=%h exp=00000022", dmo_done); end
  endtask

  task automatic test_reset_mid();
    int rk;
    rk = (WAIT < 3) ? WAIT : 3;
    mem_r_en_input = 1'b1; alu_res_input = 32'd1028;
    for (int k = 1; k <= rk; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; set_idle();
    @(negedge clk);
    checks++; if (ext_r_en !== 1'b1) begin failures++; $display("FAIL rm_before got r=%b exp=1", ext_r_en); end
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL rm_freeze got=%b exp=0", freeze); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ext_r_en !== 1'b0 || ext_addr !== 16'h0) begin failures++; $display("FAIL rm_after got r=%b a=%h exp 0/0000", ext_r_en, ext_addr); end
    checks++; if (data_mem_output !== 32'h0) begin failures++; $display("FAIL rm_dmo got=%h exp=0", data_mem_output); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(1'b0, 1'b1, 32'd1032, 32'h0);
    checks++; if (ren_cnt !== WAIT || freeze_cnt !== WAIT + 1) begin failures++; $display("FAIL rm_next_cnt got r=%0d f=%0d exp %0d/%0d", ren_cnt, freeze_cnt, WAIT, WAIT + 1); end
    checks++; if (dmo_pre !== 32'h0) begin failures++; $display("FAIL rm_next_early got=%h exp=0", dmo_pre); end
    checks++; if (dmo_done !== 32'h22) begin failures++; $display("FAIL rm_next_dmo got=%h exp=00000022", dmo_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_non_mem();
    test_back_to_back();
    test_rw_both();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Parametrised, multi-cycle successor to the single-cycle MEM stage of the ARM pipeline. It replaces the internal zero-wait data RAM with an external SRAM-style port of fixed latency. It translates the byte address, sequences each access with a small FSM, and raises `freeze` to stall the upstream pipeline until the access completes. It sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- `DATA_W`, 32, data word width.
- `ADDR_W`, 32, width of `alu_res_input`.
- `MEM_ADDR_W`, 16, width of the external word address.
- `WAIT_CYCLES`, 5, external access latency in cycles; legal range ≥1.
- `BASE_ADDR`, 1024, byte address mapped to external word 0.

Ports:
- Reset is synchronous and active-high; one clock.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_w_en_input` in 1: store request.
- `mem_r_en_input` in 1: load request.
- `wb_en_input` in 1: write-back enable, passed through.
- `dest_input` in 4: destination register, passed through.
- `alu_res_input` in ADDR_W: byte address, or ALU result.
- `val_rm_i` in DATA_W: store data.
- `wb_en_output`, `mem_r_en_output`, `dest_output`, `alu_res_output` out 1/1/4/ADDR_W: combinational copies of the matching inputs.
- `data_mem_output` out DATA_W: registered load data.
- `freeze` out 1: stall request to PC, IF/ID, ID/EX and EX/MEM registers.
- `ext_addr` out MEM_ADDR_W: external word address.
- `ext_w_en` out 1: external write strobe.
- `ext_r_en` out 1: external read strobe.
- `ext_wdata` out DATA_W: external write data.
- `ext_rdata` in DATA_W: external read data, valid in the last access cycle.

## Operation
FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - A request is present when `mem_r_en_input` or `mem_w_en_input` is high.
  - On a request: latch the address, write data and operation; clear the counter; go to ACCESS.
  - With no request: stay in IDLE.
- **ACCESS**
  - Hold `ext_addr` and `ext_wdata` from the latched values.
  - Assert `ext_r_en` for a load or `ext_w_en` for a store; the counter increments each cycle.
  - When counter == WAIT_CYCLES-1: a load captures `ext_rdata` into the read-data register. Then go to DONE.
- **DONE**
  - `freeze` is low, so the pipeline advances on this edge.
  - Return to IDLE without sampling the request inputs. The frozen request is still visible here and must not be re-issued.
- `freeze` = (IDLE & request) | ACCESS. This is combinational, so the stall applies in the same cycle the request arrives.
- Address: `ext_addr` = ((alu_res - BASE_ADDR) >> 2), truncated to MEM_ADDR_W.
  - Subtraction is modulo 2^ADDR_W. Out-of-range addresses wrap silently.
  - Bits [1:0] are ignored.
- If read and write are requested together, the write wins and no read data is captured.
- The read-data register changes only on load completion. Stores and idle cycles leave it unchanged.
- Pass-through outputs are purely combinational, identical to the single-cycle MEM stage.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - Read-data register 0, so `data_mem_output` = 0.
  - `ext_r_en` = `ext_w_en` = 0; `ext_addr` = 0; `ext_wdata` = 0.
  - `freeze` is forced to 0 while `rst` is high.
- Request accepted in cycle t (IDLE). ACCESS covers cycles t+1 … t+WAIT_CYCLES. DONE is cycle t+WAIT_CYCLES+1.
  - `freeze` is high for exactly WAIT_CYCLES+1 cycles (t … t+WAIT_CYCLES).
  - External strobes are high for exactly WAIT_CYCLES cycles.
  - `data_mem_output` is valid from cycle t+WAIT_CYCLES+1 and is held until the next load completes.
- Back-to-back memory instructions: the second request is seen in the first IDLE cycle after DONE. Minimum spacing is WAIT_CYCLES+2 cycles per access.
- Reset mid-access: at the next edge the FSM goes to IDLE and strobes drop. The read-data register clears and the partial access is abandoned.
- Outside ACCESS, `ext_addr` and `ext_wdata` hold their last values. Strobes are 0 outside ACCESS.

## Structure
- Shared package `arm_mem_pkg`:
  - FSM state enum (IDLE/ACCESS/DONE).
  - Default `BASE_ADDR` and `WAIT_CYCLES` constants, reused by the SRAM behavioural model and by the hazard/forwarding freeze logic.
- A sub-module `sram_model` (behavioural, parametrised by the same constants, fixed latency WAIT_CYCLES) belongs in the testbench only. It is not instantiated in this block.
- The counter is in-line; it is ceil(log2(WAIT_CYCLES))+1 bits wide.

## Test plan
- Reset: hold `rst` 2 cycles with a read request pending. Required: all outputs 0, `freeze` 0; after release, FSM starts the access in the next cycle.
- Store then load: store 0xDEADBEEF to address 1028 (`ext_addr`=1), then load from 1028.
  - `ext_w_en` high for 5 cycles; `freeze` high for 6 cycles.
  - Load returns 0xDEADBEEF on `data_mem_output` at cycle t+6.
- Non-memory instruction (`alu_res`=0x55, no enables): `freeze` stays 0, no strobes, pass-throughs match, `data_mem_output` unchanged.
- Back-to-back loads at 1024 and 1032 (model data 0x11, 0x22): two separate accesses, each with `freeze` high for 6 cycles. `ext_addr` is 0 then 2, outputs are 0x11 then 0x22, and DONE never re-issues.
- Simultaneous `r`/`w` at 1036 with 0xCAFE0001: only `ext_w_en` is strobed and the read-data register is unchanged.
- Reset asserted at the 3rd ACCESS cycle: strobes 0 at the next edge; the next load completes normally with WAIT_CYCLES=1 and WAIT_CYCLES=5 builds.
